gshare_fetch_predictor: RTL and testbench

- IF-stage direction and target predictor for the RVS192 GSHARE_BP configuration.
- Sits directly upstream of EX branch handling. It produces the GBP_predict counter and GBHR snapshot that travel down the pipe in br_check, plus the predicted next-PC redirect.
- It consumes the EX br_update result (update, actual, wrong, GBHR_old, GBP_predict_update) to train its PHT and BTB and to repair the speculative global history.

---
 rtl/gshare_fetch_predictor.sv | 143 ++++++++++++++
 tb/tb_gshare_fetch_predictor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_fetch_predictor.sv
// gshare_fetch_predictor: IF-stage gshare direction predictor (PHT) plus direct-mapped BTB.
// Latency: reads are combinational from pc_if; training and history updates land at the next clk edge.
// Backpressure: none; init_busy=1 for 2^GSHARE_HISTORY_LENGTH cycles after rst and IF must stall.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   pc_if, fetch_valid           fetch PC and IF-advancing qualifier
//   init_busy                    table initialisation in progress
//   btb_hit, predict_taken,      BTB lookup result, redirect decision,
//   predict_target               and stored target for pc_if
//   gbp_predict, gbhr_out        PHT counter and GBHR snapshot for br_check
//   upd_*                        EX br_update training / history-repair inputs
module gshare_fetch_predictor #(
  parameter int PC_LENGTH             = 32,
  parameter int GSHARE_HISTORY_LENGTH = 8,
  parameter int BTB_INDEX_BITS        = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PC_LENGTH-1:0]             pc_if,
  input  logic                             fetch_valid,
  output logic                             init_busy,
  output logic                             btb_hit,
  output logic                             predict_taken,
  output logic [PC_LENGTH-1:0]             predict_target,
  output logic [1:0]                       gbp_predict,
  output logic [GSHARE_HISTORY_LENGTH-1:0] gbhr_out,
  input  logic                             upd_valid,
  input  logic                             upd_actual,
  input  logic                             upd_wrong,
  input  logic [GSHARE_HISTORY_LENGTH-1:0] upd_gbhr_old,
  input  logic [1:0]                       upd_counter,
  input  logic [PC_LENGTH-1:0]             upd_pc,
  input  logic [PC_LENGTH-1:0]             upd_target
);

  localparam int GHL   = GSHARE_HISTORY_LENGTH;
  localparam int BIB   = BTB_INDEX_BITS;
  localparam int PHT_N = 1 << GHL;
  localparam int BTB_N = 1 << BIB;
  localparam int TAG_W = PC_LENGTH - BIB - 2;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [GHL-1:0]       init_idx_q, init_idx_d;
  logic [GHL-1:0]       gbhr_q, gbhr_d;

  logic [1:0]           pht_q     [PHT_N];
  logic [1:0]           pht_d     [PHT_N];
  logic                 btb_vld_q [BTB_N];
  logic                 btb_vld_d [BTB_N];
  logic [TAG_W-1:0]     btb_tag_q [BTB_N];
  logic [TAG_W-1:0]     btb_tag_d [BTB_N];
  logic [PC_LENGTH-1:0] btb_tgt_q [BTB_N];
  logic [PC_LENGTH-1:0] btb_tgt_d [BTB_N];

  // Index / tag slicing for the fetch side and the update side.
  logic [GHL-1:0]   rd_pht_idx, wr_pht_idx;
  logic [BIB-1:0]   rd_btb_idx, wr_btb_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  // Byte-offset bits of the PCs never take part in indexing.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

  assign rd_pht_idx = pc_if[GHL+1:2] ^ gbhr_q;
  assign wr_pht_idx = upd_pc[GHL+1:2] ^ upd_gbhr_old;
  assign rd_btb_idx = pc_if[BIB+1:2];
  assign wr_btb_idx = upd_pc[BIB+1:2];
  assign rd_tag     = pc_if[PC_LENGTH-1:BIB+2];
  assign wr_tag     = upd_pc[PC_LENGTH-1:BIB+2];

  // Combinational read path; tables are only written at the clock edge, so a
  // same-cycle write to the entry being read shows the old value.
  always_comb begin
    init_busy      = (state_q == ST_INIT);
    gbp_predict    = pht_q[rd_pht_idx];
    predict_target = btb_tgt_q[rd_btb_idx];
    btb_hit        = ~init_busy & btb_vld_q[rd_btb_idx] & (btb_tag_q[rd_btb_idx] == rd_tag);
    predict_taken  = btb_hit & gbp_predict[1] & ~init_busy;
    gbhr_out       = gbhr_q;
  end

  // Next-state: INIT sweeps the tables, RUN trains them and steers history.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    gbhr_d     = gbhr_q;
    pht_d      = pht_q;
    btb_vld_d  = btb_vld_q;
    btb_tag_d  = btb_tag_q;
    btb_tgt_d  = btb_tgt_q;

    if (state_q == ST_INIT) begin
      // BTB is smaller than the PHT, so each valid bit is cleared several times.
      pht_d[init_idx_q]                = 2'b01;
      btb_vld_d[init_idx_q[BIB-1:0]]   = 1'b0;
      init_idx_d                       = init_idx_q + GHL'(1);
      if (&init_idx_q) begin
        state_d = ST_RUN;
      end
    end else begin
      if (upd_valid) begin
        // EX already computed the saturated counter; store it verbatim.
        pht_d[wr_pht_idx] = upd_counter;
        if (upd_actual) begin
          btb_vld_d[wr_btb_idx] = 1'b1;
          btb_tag_d[wr_btb_idx] = wr_tag;
          btb_tgt_d[wr_btb_idx] = upd_target;
        end
      end

      // Misprediction repair beats the speculative shift from this cycle's fetch.
      if (upd_valid && upd_wrong) begin
        gbhr_d = {upd_gbhr_old[GHL-2:0], upd_actual};
      end else if (fetch_valid && btb_hit) begin
        gbhr_d = {gbhr_q[GHL-2:0], predict_taken};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      gbhr_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      gbhr_q     <= gbhr_d;
    end
  end

  // Table storage has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    pht_q     <= pht_d;
    btb_vld_q <= btb_vld_d;
    btb_tag_q <= btb_tag_d;
    btb_tgt_q <= btb_tgt_d;
  end

endmodule

// File: tb/tb_gshare_fetch_predictor.sv
// tb_gshare_fetch_predictor: directed checks of init sweep, training, history repair,
// aliasing, same-cycle collision and mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
module tb_gshare_fetch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        fetch_valid;
  logic        init_busy;
  logic        btb_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [1:0]  gbp_predict;
  logic [7:0]  gbhr_out;
  logic        upd_valid;
  logic        upd_actual;
  logic        upd_wrong;
  logic [7:0]  upd_gbhr_old;
  logic [1:0]  upd_counter;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  gshare_fetch_predictor #(
    .PC_LENGTH(32), .GSHARE_HISTORY_LENGTH(8), .BTB_INDEX_BITS(6)
  ) dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .fetch_valid(fetch_valid),
    .init_busy(init_busy), .btb_hit(btb_hit), .predict_taken(predict_taken),
    .predict_target(predict_target), .gbp_predict(gbp_predict), .gbhr_out(gbhr_out),
    .upd_valid(upd_valid), .upd_actual(upd_actual), .upd_wrong(upd_wrong),
    .upd_gbhr_old(upd_gbhr_old), .upd_counter(upd_counter), .upd_pc(upd_pc),
    .upd_target(upd_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one edge and land 1 unit after it, ready to drive inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_upd();
    upd_valid = 0; upd_actual = 0; upd_wrong = 0; upd_gbhr_old = 0;
    upd_counter = 0; upd_pc = 0; upd_target = 0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic act, input logic wrong,
                           input logic [7:0] old, input logic [1:0] ctr, input logic [31:0] tgt);
    upd_valid = 1; upd_pc = pc; upd_actual = act; upd_wrong = wrong;
    upd_gbhr_old = old; upd_counter = ctr; upd_target = tgt;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1; pc_if = 32'h400; fetch_valid = 0; clear_upd();
    tick(); tick();
    #1;
    total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL rst_init_busy got=%0h exp=1", init_busy); end
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL rst_btb_hit got=%0h exp=0", btb_hit); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL rst_predict_taken got=%0h exp=0", predict_taken); end
    total++; if (gbhr_out !== 8'h00) begin bad++; $display("FAIL rst_gbhr got=%0h exp=0", gbhr_out); end
    @(posedge clk); #1;
    rst = 0;
    cnt = 0;
    #1;
    while (init_busy === 1'b1 && cnt < 1000) begin
      cnt++;
      tick(); #1;
    end
    total++; if (cnt !== 256) begin bad++; $display("FAIL init_cycles got=%0d exp=256", cnt); end
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL init_done got=%0h exp=0", init_busy); end
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL post_init_hit got=%0h exp=0", btb_hit); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL post_init_taken got=%0h exp=0", predict_taken); end
    total++; if (gbp_predict !== 2'b01) begin bad++; $display("FAIL post_init_gbp got=%0h exp=1", gbp_predict); end
    total++; if (gbhr_out !== 8'h00) begin bad++; $display("FAIL post_init_gbhr got=%0h exp=0", gbhr_out); end
    tick();
  endtask

  task automatic test_training();
    drive_upd(32'h100, 1, 0, 8'h00, 2'b11, 32'h200);
    tick();
    clear_upd();
    pc_if = 32'h100; fetch_valid = 1;
    #1;
    total++; if (btb_hit !== 1'b1) begin bad++; $display("FAIL train_hit got=%0h exp=1", btb_hit); end
    total++; if (gbp_predict !== 2'b11) begin bad++; $display("FAIL train_gbp got=%0h exp=3", gbp_predict); end
    total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL train_taken got=%0h exp=1", predict_taken); end
    total++; if (predict_target !== 32'h200) begin bad++; $display("FAIL train_target got=%0h exp=200", predict_target); end
    total++; if (gbhr_out !== 8'h00) begin bad++; $display("FAIL train_gbhr_pre got=%0h exp=0", gbhr_out); end
    tick();
    fetch_valid = 0;
    #1;
    total++; if (gbhr_out !== 8'h01) begin bad++; $display("FAIL train_gbhr_shift got=%0h exp=1", gbhr_out); end
    tick();
  endtask

  task automatic test_recovery();
    // Train PHT[0x40^0x01] taken so the next fetch shifts in a 1 -> gbhr 0x03.
    drive_upd(32'h100, 1, 0, 8'h01, 2'b11, 32'h200);
    tick();
    clear_upd();
    pc_if = 32'h100; fetch_valid = 1;
    #1;
    total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL rec_spec_taken got=%0h exp=1", predict_taken); end
    tick();
    #1;
    total++; if (gbhr_out !== 8'h03) begin bad++; $display("FAIL rec_spec_gbhr got=%0h exp=3", gbhr_out); end
    // Hitting fetch plus mispredict repair in the same cycle.
    drive_upd(32'h800, 0, 1, 8'h05, 2'b00, 32'h0);
    #1;
    total++; if (btb_hit !== 1'b1) begin bad++; $display("FAIL rec_fetch_hit got=%0h exp=1", btb_hit); end
    tick();
    clear_upd();
    fetch_valid = 0;
    #1;
    total++; if (gbhr_out !== 8'h0A) begin bad++; $display("FAIL rec_gbhr got=%0h exp=0a", gbhr_out); end
    tick();
  endtask

  task automatic test_aliasing();
    pc_if = 32'h1100; fetch_valid = 0;
    #1;
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL alias_hit got=%0h exp=0", btb_hit); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL alias_taken got=%0h exp=0", predict_taken); end
    drive_upd(32'h1100, 1, 0, 8'h00, 2'b11, 32'h300);
    tick();
    clear_upd();
    #1;
    total++; if (btb_hit !== 1'b1) begin bad++; $display("FAIL alias_new_hit got=%0h exp=1", btb_hit); end
    total++; if (predict_target !== 32'h300) begin bad++; $display("FAIL alias_new_target got=%0h exp=300", predict_target); end
    pc_if = 32'h100;
    #1;
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL alias_old_hit got=%0h exp=0", btb_hit); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL alias_old_taken got=%0h exp=0", predict_taken); end
    tick();
  endtask

  task automatic test_collision();
    // gbhr is 0x0A; fetch 0x400 reads PHT[0x0A], and the update targets the same entry.
    pc_if = 32'h400; fetch_valid = 0;
    drive_upd(32'h400, 0, 0, 8'h0A, 2'b11, 32'h0);
    #1;
    total++; if (gbp_predict !== 2'b01) begin bad++; $display("FAIL coll_same_cycle got=%0h exp=1", gbp_predict); end
    tick();
    clear_upd();
    #1;
    total++; if (gbp_predict !== 2'b11) begin bad++; $display("FAIL coll_next_cycle got=%0h exp=3", gbp_predict); end
    tick();
  endtask

  task automatic test_midrun_reset();
    int cnt;
    drive_upd(32'h100, 1, 0, 8'h00, 2'b11, 32'h200);
    tick();
    clear_upd();
    while (cyc < 500) tick();
    rst = 1;
    tick();
    rst = 0;
    pc_if = 32'h100; fetch_valid = 1;
    cnt = 0;
    #1;
    while (init_busy === 1'b1 && cnt < 1000) begin
      if (cnt == 3) begin
        total++; if (btb_hit !== 1'b0 || predict_taken !== 1'b0) begin
          bad++; $display("FAIL init_outputs got=%0h%0h exp=00", btb_hit, predict_taken);
        end
      end
      // Training pulse late in INIT, after the last sweep of BTB[0] and PHT[0x40].
      if (cnt >= 250 && cnt <= 252) drive_upd(32'h100, 1, 1, 8'h00, 2'b11, 32'h200);
      else clear_upd();
      cnt++;
      tick(); #1;
    end
    clear_upd();
    fetch_valid = 0;
    #1;
    total++; if (cnt !== 256) begin bad++; $display("FAIL midrst_cycles got=%0d exp=256", cnt); end
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL midrst_hit got=%0h exp=0", btb_hit); end
    total++; if (gbp_predict !== 2'b01) begin bad++; $display("FAIL midrst_gbp got=%0h exp=1", gbp_predict); end
    total++; if (gbhr_out !== 8'h00) begin bad++; $display("FAIL midrst_gbhr got=%0h exp=0", gbhr_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_training();
    test_recovery();
    test_aliasing();
    test_collision();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
